// File: rtl/event_bcd_counter_pkg.sv
// Shared types and seven-segment constants for the event BCD counter.
package event_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int DIGITS_MAX = 4;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/event_bcd_counter_if.sv
// Event strobe/control inputs and count/display outputs of the event BCD counter.
interface event_bcd_counter_if #(
  parameter int DIGITS = 2
);

  logic                  pulse_in;
  logic                  enable;
  logic                  clear;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [7*DIGITS-1:0]   hex;
  logic                  overflow;

  modport master (
    output pulse_in, enable, clear,
    input  count_bcd, hex, overflow
  );

  modport slave (
    input  pulse_in, enable, clear,
    output count_bcd, hex, overflow
  );

endinterface

// File: rtl/event_bcd_counter_seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern; non-BCD codes blank the display.
module seg7_decoder
  import event_cnt_pkg::*;
(
  input  bcd_digit_t  digit_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/event_bcd_counter.sv
// Rising-edge event counter in DIGITS BCD digits with per-digit HEX decode and sticky overflow.
// Define EVENT_CNT_SATURATE_EN to hold at all-9s on overflow instead of wrapping to zero.
module event_bcd_counter
  import event_cnt_pkg::*;
#(
  parameter int DIGITS = 2
)(
  input  logic              Clock,
  input  logic              Resetn,
  event_bcd_counter_if.slave bus
);

  logic                pulse_d_q;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                event_w;
  logic                at_terminal;
  logic                carry;
  logic [7*DIGITS-1:0] hex_w;

  assign event_w = bus.pulse_in & ~pulse_d_q;

  // NOTE: defaults are assigned first so no branch leaves a signal unassigned (no latch).
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    at_terminal = 1'b1;
    carry       = 1'b1;

    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[i*4 +: 4] != 4'd9) at_terminal = 1'b0;
    end

    if (bus.clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (bus.enable && event_w) begin
      if (at_terminal) begin
        overflow_d = 1'b1;
`ifdef EVENT_CNT_SATURATE_EN
        count_d    = count_q;
`else
        count_d    = '0;
`endif
      end else begin
        // Ripple the carry upward; a digit at 9 rolls to 0 and passes it on
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (count_q[i*4 +: 4] == 4'd9) begin
              count_d[i*4 +: 4] = 4'd0;
            end else begin
              count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pulse_d_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pulse_d_q  <= bus.pulse_in;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decoder u_seg (
      .digit_i (count_q[g*4 +: 4]),
      .seg_o   (hex_w[g*7 +: 7])
    );
  end

  assign bus.count_bcd = count_q;
  assign bus.hex       = hex_w;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_event_bcd_counter.sv
// Self-checking bench for event_bcd_counter (DIGITS=2): vector table, directed corners, random vs model.
module tb_event_bcd_counter;

  localparam int D    = 2;
  localparam int MAXV = 99;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  event_bcd_counter_if #(.DIGITS(D)) bus ();

  event_bcd_counter #(.DIGITS(D)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain decimal count, sticky flag, previous strobe
  int m_cnt;
  bit m_ovf;
  bit m_prev;

  logic [6:0] seg_lut [10];

  typedef struct {
    bit         p;
    bit         e;
    bit         c;
    logic [7:0] cnt;
    bit         ovf;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] tens, ones;
    tens = 4'((n / 10) % 10);
    ones = 4'(n % 10);
    return {tens, ones};
  endfunction

  function automatic logic [13:0] to_hex(input int n);
    return {seg_lut[(n / 10) % 10], seg_lut[n % 10]};
  endfunction

  function automatic void model_reset();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endfunction

  function automatic void model_edge(input bit p, input bit e, input bit c);
    bit ev;
    ev = p && !m_prev;
    if (c) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (e && ev) begin
      if (m_cnt == MAXV) begin
        m_ovf = 1'b1;
`ifndef EVENT_CNT_SATURATE_EN
        m_cnt = 0;
`endif
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_prev = p;
  endfunction

  // Called at a negedge: drive inputs, take one rising edge, compare at the next negedge
  task automatic step(input bit p, input bit e, input bit c, input string name);
    bus.pulse_in = p;
    bus.enable   = e;
    bus.clear    = c;
    @(posedge clk);
    model_edge(p, e, c);
    @(negedge clk);
    check({name, ".count"}, 32'(bus.count_bcd), 32'(to_bcd(m_cnt)));
    check({name, ".hex"},   32'(bus.hex),       32'(to_hex(m_cnt)));
    check({name, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
  endtask

  task automatic pulses(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b1, 1'b0, name);
      step(1'b0, 1'b1, 1'b0, name);
    end
  endtask

  initial begin
    seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
    seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
    seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000; seg_lut[8] = 7'b0000000;
    seg_lut[9] = 7'b0010000;

    // Clear, long high (counts once), three isolated pulses, disabled event, enable rising mid-pulse
    tbl.push_back('{p:0, e:1, c:1, cnt:8'h00, ovf:0});
    for (int k = 0; k < 5; k++) tbl.push_back('{p:1, e:1, c:0, cnt:8'h01, ovf:0});
    tbl.push_back('{p:0, e:1, c:0, cnt:8'h01, ovf:0});
    tbl.push_back('{p:1, e:1, c:0, cnt:8'h02, ovf:0});
    tbl.push_back('{p:0, e:1, c:0, cnt:8'h02, ovf:0});
    tbl.push_back('{p:1, e:1, c:0, cnt:8'h03, ovf:0});
    tbl.push_back('{p:0, e:1, c:0, cnt:8'h03, ovf:0});
    tbl.push_back('{p:1, e:1, c:0, cnt:8'h04, ovf:0});
    tbl.push_back('{p:0, e:1, c:0, cnt:8'h04, ovf:0});
    tbl.push_back('{p:1, e:0, c:0, cnt:8'h04, ovf:0});
    tbl.push_back('{p:1, e:1, c:0, cnt:8'h04, ovf:0});
    tbl.push_back('{p:0, e:1, c:0, cnt:8'h04, ovf:0});

    // Reset held with the strobe high
    model_reset();
    rst_n        = 1'b0;
    bus.pulse_in = 1'b1;
    bus.enable   = 1'b1;
    bus.clear    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.count", 32'(bus.count_bcd), 32'h00);
    check("reset.hex",   32'(bus.hex),       32'h2040);
    check("reset.ovf",   32'(bus.overflow),  32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, "first_edge");
    check("first_edge.const", 32'(bus.count_bcd), 32'h01);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].e, tbl[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tcount", i), 32'(bus.count_bcd), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.tovf", i),   32'(bus.overflow),  32'(tbl[i].ovf));
    end

    // Decimal carry
    step(1'b0, 1'b1, 1'b1, "carry_clr");
    pulses(10, "carry");
    check("carry.const",  32'(bus.count_bcd), 32'h10);
    check("carry.hex_lo", 32'(bus.hex[6:0]),  32'(7'b1000000));
    check("carry.hex_hi", 32'(bus.hex[13:7]), 32'(7'b1111001));

    // Terminal count and beyond
    step(1'b0, 1'b1, 1'b1, "tc_clr");
    pulses(99, "tc_up");
    check("tc99.count", 32'(bus.count_bcd), 32'h99);
    check("tc99.ovf",   32'(bus.overflow),  32'h0);
    pulses(1, "tc_hit");
`ifdef EVENT_CNT_SATURATE_EN
    check("tc100.count", 32'(bus.count_bcd), 32'h99);
`else
    check("tc100.count", 32'(bus.count_bcd), 32'h00);
`endif
    check("tc100.ovf", 32'(bus.overflow), 32'h1);
    pulses(1, "tc_more");
`ifdef EVENT_CNT_SATURATE_EN
    check("tc101.count", 32'(bus.count_bcd), 32'h99);
`else
    check("tc101.count", 32'(bus.count_bcd), 32'h01);
`endif
    check("tc101.ovf", 32'(bus.overflow), 32'h1);

    // Clear beats a simultaneous event and drops the sticky flag
    step(1'b1, 1'b1, 1'b1, "clr_ovf");
    check("clr_ovf.count", 32'(bus.count_bcd), 32'h00);
    check("clr_ovf.ovf",   32'(bus.overflow),  32'h0);
    step(1'b0, 1'b1, 1'b0, "prio_lo");
    pulses(37, "prio_up");
    check("prio37.count", 32'(bus.count_bcd), 32'h37);
    step(1'b1, 1'b1, 1'b1, "prio_clr");
    check("prio_clr.count", 32'(bus.count_bcd), 32'h00);
    step(1'b0, 1'b1, 1'b0, "prio_lo2");
    step(1'b1, 1'b0, 1'b0, "prio_dis");
    step(1'b1, 1'b1, 1'b0, "prio_late_en");
    check("prio_dis.count", 32'(bus.count_bcd), 32'h00);
    step(1'b0, 1'b1, 1'b0, "prio_lo3");

    // Asynchronous reset between edges
    pulses(42, "async_up");
    check("async42.count", 32'(bus.count_bcd), 32'h42);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async.count", 32'(bus.count_bcd), 32'h00);
    check("async.hex",   32'(bus.hex),       32'h2040);
    check("async.ovf",   32'(bus.overflow),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 9) != 0),
           bit'($urandom_range(0, 511) == 0),
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
